decode_stage: RTL and testbench

Single-entry pipelined RV32I decode stage sitting between fetch and execute. Accepts one fetched instruction per cycle over a valid/ready handshake, reads the register file, and registers a fully resolved execute packet. The packet carries the 4-bit ALU function code, both selected ALU operands, the immediate, the destination register and the control flags. It is the producer side of the ALU's `func`/`in1`/`in2` interface.

---
 rtl/riscv_pkg.sv | 71 +++++++
 rtl/imm_gen.sv | 23 ++
 rtl/decode_stage.sv | 139 +++++++++++++
 tb/tb_decode_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes, funct3 codes, ALU function codes and the execute packet shared by decode and ALU.
package riscv_pkg;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SHL = 4'd2;
  localparam logic [3:0] ALU_SHR = 4'd3;
  localparam logic [3:0] ALU_SHA = 4'd4;
  localparam logic [3:0] ALU_OR  = 4'd5;
  localparam logic [3:0] ALU_AND = 4'd6;
  localparam logic [3:0] ALU_XOR = 4'd7;
  localparam logic [3:0] ALU_EQ  = 4'd8;
  localparam logic [3:0] ALU_NE  = 4'd9;
  localparam logic [3:0] ALU_LT  = 4'd10;
  localparam logic [3:0] ALU_GE  = 4'd11;
  localparam logic [3:0] ALU_LTU = 4'd12;
  localparam logic [3:0] ALU_GEU = 4'd13;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  typedef struct packed {
    logic [3:0]  func;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] imm;
    logic [31:0] rs2_data;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wb;
    logic        load;
    logic        store;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic [2:0]  funct3;
    logic        illegal;
  } pkt_t;

  // alt selects SUB over ADD and SHA over SHR
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SHL;
      3'b010:  alu_op = ALU_LT;
      3'b011:  alu_op = ALU_LTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SHA : ALU_SHR;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended I/S/B/U/J immediate extraction selected by opcode.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);
  logic [6:0]  opc;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  always_comb begin
    opc   = instr[6:0];
    i_imm = {{20{instr[31]}}, instr[31:20]};
    s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    u_imm = {instr[31:12], 12'b0};
    j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    imm   = (opc == OPC_OP_IMM || opc == OPC_LOAD || opc == OPC_JALR) ? i_imm :
            (opc == OPC_STORE)                   ? s_imm :
            (opc == OPC_BRANCH)                  ? b_imm :
            (opc == OPC_LUI || opc == OPC_AUIPC) ? u_imm :
            (opc == OPC_JAL)                     ? j_imm : 32'd0;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with register-file read and a single registered execute packet
// behind a valid/ready handshake.
module decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        hazard,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_func,
  output logic [31:0] out_in1,
  output logic [31:0] out_in2,
  output logic [31:0] out_imm,
  output logic [31:0] out_rs2_data,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rd,
  output logic        out_wb,
  output logic        out_load,
  output logic        out_store,
  output logic        out_branch,
  output logic        out_jal,
  output logic        out_jalr,
  output logic [2:0]  out_funct3,
  output logic        out_illegal
);
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm;
  logic        accept, valid_d, valid_q;
  pkt_t        dec, pkt_d, pkt_q;

  imm_gen u_imm_gen (.instr(in_instr), .imm(imm));

  assign opc      = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign f7       = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign in_ready = !hazard && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    dec          = '0;
    dec.func     = ALU_ADD;
    dec.imm      = imm;
    dec.rs2_data = rs2_data;
    dec.pc       = in_pc;
    dec.rd       = in_instr[11:7];
    dec.funct3   = f3;
    case (opc)
      OPC_OP: begin
        dec.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
        dec.func    = alu_op(f3, f7[5]);
        dec.in1     = rs1_data;
        dec.in2     = rs2_data;
        dec.wb      = 1'b1;
      end
      OPC_OP_IMM: begin
        // shifts take the 5-bit shamt, not the full I-immediate that also holds funct7
        dec.illegal = (f3 == 3'b001 && f7 != 7'h00) ||
                      (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
        dec.func    = alu_op(f3, f3 == 3'b101 && f7[5]);
        dec.in1     = rs1_data;
        dec.in2     = (f3 == 3'b001 || f3 == 3'b101) ? {27'd0, in_instr[24:20]} : imm;
        dec.wb      = 1'b1;
      end
      OPC_BRANCH: begin
        dec.func    = (f3 == F3_BEQ)  ? ALU_EQ  : (f3 == F3_BNE)  ? ALU_NE  :
                      (f3 == F3_BLT)  ? ALU_LT  : (f3 == F3_BGE)  ? ALU_GE  :
                      (f3 == F3_BLTU) ? ALU_LTU : ALU_GEU;
        dec.illegal = (f3 == 3'b010 || f3 == 3'b011);
        dec.in1     = rs1_data;
        dec.in2     = rs2_data;
        dec.branch  = 1'b1;
      end
      OPC_LUI:   begin dec.in2 = imm; dec.wb = 1'b1; end
      OPC_AUIPC: begin dec.in1 = in_pc; dec.in2 = imm; dec.wb = 1'b1; end
      OPC_JAL:   begin dec.in1 = in_pc; dec.in2 = 32'd4; dec.wb = 1'b1; dec.jal = 1'b1; end
      OPC_JALR:  begin dec.in1 = in_pc; dec.in2 = 32'd4; dec.wb = 1'b1; dec.jalr = 1'b1; end
      OPC_LOAD:  begin dec.in1 = rs1_data; dec.in2 = imm; dec.wb = 1'b1; dec.load = 1'b1; end
      OPC_STORE: begin dec.in1 = rs1_data; dec.in2 = imm; dec.store = 1'b1; end
      default:   dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.func   = ALU_ADD;
      dec.in1    = '0;
      dec.in2    = '0;
      dec.wb     = 1'b0;
      dec.load   = 1'b0;
      dec.store  = 1'b0;
      dec.branch = 1'b0;
      dec.jal    = 1'b0;
      dec.jalr   = 1'b0;
    end
    dec.wb = dec.wb && (dec.rd != 5'd0);
  end

  always_comb begin
    valid_d = flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : valid_q;
    pkt_d   = accept ? dec : pkt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_func     = pkt_q.func;
  assign out_in1      = pkt_q.in1;
  assign out_in2      = pkt_q.in2;
  assign out_imm      = pkt_q.imm;
  assign out_rs2_data = pkt_q.rs2_data;
  assign out_pc       = pkt_q.pc;
  assign out_rd       = pkt_q.rd;
  assign out_wb       = pkt_q.wb;
  assign out_load     = pkt_q.load;
  assign out_store    = pkt_q.store;
  assign out_branch   = pkt_q.branch;
  assign out_jal      = pkt_q.jal;
  assign out_jalr     = pkt_q.jalr;
  assign out_funct3   = pkt_q.funct3;
  assign out_illegal  = pkt_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode, handshake, flush, hazard bubbles and async reset.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, hazard, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, out_rd;
  logic [3:0]  out_func;
  logic [31:0] out_in1, out_in2, out_imm, out_rs2_data, out_pc;
  logic        out_wb, out_load, out_store, out_branch, out_jal, out_jalr, out_illegal;
  logic [2:0]  out_funct3;
  int          checks = 0;
  int          errors = 0;

  decode_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .hazard(hazard), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_func(out_func),
    .out_in1(out_in1), .out_in2(out_in2), .out_imm(out_imm),
    .out_rs2_data(out_rs2_data), .out_pc(out_pc), .out_rd(out_rd), .out_wb(out_wb),
    .out_load(out_load), .out_store(out_store), .out_branch(out_branch),
    .out_jal(out_jal), .out_jalr(out_jalr), .out_funct3(out_funct3),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    rs1_data = '0; rs2_data = '0; hazard = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in1", out_in1, 32'd0);
    chk("reset_func", {28'd0, out_func}, 32'd0);
    reset_n = 1'b1;
    cyc();
    // add x3,x1,x2
    offer(32'h002081B3, 32'h100, 32'd5, 32'd7);
    #1;
    chk("rs1_addr", {27'd0, rs1_addr}, 32'd1);
    chk("rs2_addr", {27'd0, rs2_addr}, 32'd2);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_func", {28'd0, out_func}, 32'd0);
    chk("add_in1", out_in1, 32'd5);
    chk("add_in2", out_in2, 32'd7);
    chk("add_rd", {27'd0, out_rd}, 32'd3);
    chk("add_wb", {31'd0, out_wb}, 32'd1);
    chk("add_pc", out_pc, 32'h100);
    // sub x3,x1,x2
    offer(32'h402081B3, 32'h104, 32'd5, 32'd7);
    cyc();
    chk("sub_func", {28'd0, out_func}, 32'd1);
    chk("sub_in2", out_in2, 32'd7);
    // srai x5,x6,3
    offer(32'h40335293, 32'h108, 32'h80, 32'd0);
    cyc();
    chk("srai_func", {28'd0, out_func}, 32'd4);
    chk("srai_in2", out_in2, 32'd3);
    chk("srai_rd", {27'd0, out_rd}, 32'd5);
    // beq x1,x2,+8
    offer(32'h00208463, 32'h10C, 32'd5, 32'd7);
    cyc();
    chk("beq_func", {28'd0, out_func}, 32'd8);
    chk("beq_branch", {31'd0, out_branch}, 32'd1);
    chk("beq_imm", out_imm, 32'd8);
    chk("beq_wb", {31'd0, out_wb}, 32'd0);
    // lui x1,0x12345
    offer(32'h123450B7, 32'h110, 32'd99, 32'd0);
    cyc();
    chk("lui_func", {28'd0, out_func}, 32'd0);
    chk("lui_in1", out_in1, 32'd0);
    chk("lui_in2", out_in2, 32'h12345000);
    // jal x1,+8
    offer(32'h008000EF, 32'h200, 32'd0, 32'd0);
    cyc();
    chk("jal_in1", out_in1, 32'h200);
    chk("jal_in2", out_in2, 32'd4);
    chk("jal_imm", out_imm, 32'd8);
    chk("jal_flag", {31'd0, out_jal}, 32'd1);
    // backpressure: addi x1/x2/x3, x0, 1/2/3
    offer(32'h00100093, 32'h300, 32'd0, 32'd0);
    cyc();
    chk("bp_i1", out_in2, 32'd1);
    out_ready = 1'b0;
    offer(32'h00200113, 32'h304, 32'd0, 32'd0);
    #1;
    chk("bp_in_ready0", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("bp_hold1", out_in2, 32'd1);
    chk("bp_hold1_valid", {31'd0, out_valid}, 32'd1);
    cyc();
    chk("bp_hold2", out_in2, 32'd1);
    chk("bp_hold2_rd", {27'd0, out_rd}, 32'd1);
    chk("bp_in_ready1", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("bp_i2", out_in2, 32'd2);
    chk("bp_i2_rd", {27'd0, out_rd}, 32'd2);
    offer(32'h00300193, 32'h308, 32'd0, 32'd0);
    cyc();
    chk("bp_i3", out_in2, 32'd3);
    chk("bp_i3_rd", {27'd0, out_rd}, 32'd3);
    in_valid = 1'b0;
    cyc();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);
    // flush with a live packet and an offered instruction
    offer(32'h002081B3, 32'h400, 32'd5, 32'd7);
    cyc();
    chk("fl_pre_valid", {31'd0, out_valid}, 32'd1);
    offer(32'h402081B3, 32'h404, 32'd5, 32'd7);
    out_ready = 1'b0;
    flush = 1'b1;
    cyc();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("fl_nothing", {31'd0, out_valid}, 32'd0);
    // hazard bubble
    offer(32'h002081B3, 32'h500, 32'd5, 32'd7);
    cyc();
    offer(32'h402081B3, 32'h504, 32'd5, 32'd7);
    hazard = 1'b1;
    #1;
    chk("hz_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("hz_bubble", {31'd0, out_valid}, 32'd0);
    hazard = 1'b0;
    cyc();
    chk("hz_after_valid", {31'd0, out_valid}, 32'd1);
    chk("hz_after_func", {28'd0, out_func}, 32'd1);
    // illegal encodings
    offer(32'h0000007F, 32'h600, 32'd5, 32'd7);
    cyc();
    chk("ill_opc", {31'd0, out_illegal}, 32'd1);
    chk("ill_opc_wb", {31'd0, out_wb}, 32'd0);
    offer(32'h0020A463, 32'h604, 32'd5, 32'd7);
    cyc();
    chk("ill_br", {31'd0, out_illegal}, 32'd1);
    chk("ill_br_flag", {31'd0, out_branch}, 32'd0);
    chk("ill_br_func", {28'd0, out_func}, 32'd0);
    // async reset mid-stream
    offer(32'h002081B3, 32'h700, 32'd5, 32'd7);
    cyc();
    chk("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in1", out_in1, 32'd0);
    chk("rst_in2", out_in2, 32'd0);
    chk("rst_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
